draw_scheduler: RTL

Frame-level sequencer sharing the single VGA pixel-write port among four sprite drawers (player, enemy1, enemy2, bullet). On each frame tick it requests a position update from the game datapath, then enables each active drawer in turn, one at a time, holding its start level until the drawer reports done. It muxes the active drawer's x/y/colour onto the VGA adapter with a matching plot strobe. It sits between the game datapath / drawer modules and the VGA adapter.

---
 rtl/draw_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - frame sequencer sharing the VGA write port among four sprite drawers
module draw_scheduler #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        pause,
    input  logic [3:0]  slot_mask,
    input  logic        update_done,
    input  logic [3:0]  draw_done,
    input  logic [31:0] src_x,
    input  logic [27:0] src_y,
    input  logic [11:0] src_colour,
    output logic        update_req,
    output logic [3:0]  draw_start,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic [3:0]  timeout_flags,
    output logic [7:0]  overrun_count
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, UPDATE, SELECT, DRAW, GAP} state_t;

    state_t        state;
    logic [1:0]    cur;
    logic [3:0]    frame_mask;
    logic [TW-1:0] timer;

    logic          found;
    logic [1:0]    pick;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [2:0]    sel_c;

    // Descending scan so the lowest qualifying slot wins.
    always_comb begin
        found = 1'b0;
        pick  = cur;
        for (int i = 3; i >= 0; i--) begin
            if (2'(i) >= cur && frame_mask[i]) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    always_comb begin
        sel_x = src_x[7:0];
        sel_y = src_y[6:0];
        sel_c = src_colour[2:0];
        case (cur)
            2'd0: begin sel_x = src_x[7:0];   sel_y = src_y[6:0];   sel_c = src_colour[2:0];  end
            2'd1: begin sel_x = src_x[15:8];  sel_y = src_y[13:7];  sel_c = src_colour[5:3];  end
            2'd2: begin sel_x = src_x[23:16]; sel_y = src_y[20:14]; sel_c = src_colour[8:6];  end
            2'd3: begin sel_x = src_x[31:24]; sel_y = src_y[27:21]; sel_c = src_colour[11:9]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cur           <= 2'd0;
            frame_mask    <= 4'd0;
            timer         <= '0;
            update_req    <= 1'b0;
            draw_start    <= 4'd0;
            vga_x         <= 8'd0;
            vga_y         <= 7'd0;
            vga_colour    <= 3'd0;
            vga_plot      <= 1'b0;
            busy          <= 1'b0;
            timeout_flags <= 4'd0;
            overrun_count <= 8'd0;
        end else begin
            update_req <= 1'b0;
            // Pixel fields and plot trail the drawer by one cycle to match its registered output.
            vga_plot   <= (state == DRAW);
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_c;

            if (frame_tick && state != IDLE && overrun_count != 8'hff)
                overrun_count <= overrun_count + 8'd1;

            case (state)
                IDLE: begin
                    if (frame_tick && !pause) begin
                        state      <= UPDATE;
                        frame_mask <= slot_mask;
                        cur        <= 2'd0;
                        update_req <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (update_done)
                        state <= SELECT;
                end
                SELECT: begin
                    if (found) begin
                        cur        <= pick;
                        state      <= DRAW;
                        draw_start <= 4'b0001 << pick;
                        timer      <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (draw_done[cur]) begin
                        state      <= GAP;
                        draw_start <= 4'd0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_flags[cur] <= 1'b1;
                        state              <= GAP;
                        draw_start         <= 4'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    cur <= cur + 2'd1;
                    if (cur == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= SELECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
